// File: rtl/r4mdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r4mdc_pkg
// Description : Shared definitions for the R4MDC FFT output datapath:
//               default word length / frame size, the scale_restore FSM
//               state type and the saturating left-shift helper.
// Revision    : 1.0 - initial release
// ============================================================================
package r4mdc_pkg;

    localparam int WL_DEF   = 16;
    localparam int NPTS_DEF = 64;
    localparam int SW_DEF   = 3;

    // Frame-tracking FSM of scale_restore.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Result of sat_shl: value is carried at the 64-bit working width and is
    // already clamped into the wl-bit two's complement range.
    typedef struct packed {
        logic        clip;
        logic [63:0] val;
    } sat_res_t;

    // Left-shift x (sign-extended to 64 bits) by s and saturate to a wl-bit
    // signed range. Requires wl + 2^SW - 1 <= 64 so no bits are lost.
    function automatic sat_res_t sat_shl(
        input logic signed [63:0] x,
        input logic        [7:0]  s,
        input int                 wl
    );
        sat_res_t          res;
        logic signed [63:0] full;
        logic signed [63:0] maxv;
        logic signed [63:0] minv;
        full     = x <<< s;
        maxv     = (64'sd1 <<< (wl - 1)) - 64'sd1;
        minv     = -(64'sd1 <<< (wl - 1));
        res.clip = 1'b0;
        res.val  = full;
        if (full > maxv) begin
            res.clip = 1'b1;
            res.val  = maxv;
        end else if (full < minv) begin
            res.clip = 1'b1;
            res.val  = minv;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_shift_lane.sv
`default_nettype none
// ============================================================================
// Module      : sat_shift_lane
// Description : Combinational shift-and-saturate for one component
//               (real or imaginary) of a complex sample.
//   i_x    : WL-bit two's complement input
//   i_s    : SW-bit left-shift count
//   o_y    : saturated WL-bit result
//   o_clip : result was clamped to the positive or negative rail
// Revision    : 1.0 - initial release
// ============================================================================
module sat_shift_lane
    import r4mdc_pkg::*;
#(
    parameter int WL = WL_DEF,
    parameter int SW = SW_DEF
) (
    input  logic [WL-1:0] i_x,
    input  logic [SW-1:0] i_s,
    output logic [WL-1:0] o_y,
    output logic          o_clip
);

    logic [63:0] w_x_ext;
    logic [7:0]  w_s_ext;
    sat_res_t    w_res;
    logic        w_unused_hi;

    assign w_x_ext = {{(64 - WL){i_x[WL-1]}}, i_x};
    assign w_s_ext = {{(8 - SW){1'b0}}, i_s};
    assign w_res   = sat_shl(w_x_ext, w_s_ext, WL);

    assign o_y    = w_res.val[WL-1:0];
    assign o_clip = w_res.clip;

    // Upper bits are pure sign extension of the clamped value.
    assign w_unused_hi = ^w_res.val[63:WL];

endmodule
`default_nettype wire

// File: rtl/scale_restore.sv
`default_nettype none
// ============================================================================
// Module      : scale_restore
// Description : Restores gain after the per-stage downscale of the R4MDC FFT.
//               Each complex sample is left-shifted by a per-frame amount
//               (latched on sample 0) and saturated to WL bits. One register
//               stage with valid/ready flow control.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_r/in_i/in_valid   : scaled input sample, in_ready returned
//   shift_amt            : left-shift count, sampled on sample 0 only
//   out_r/out_i/out_valid: restored sample, out_ready from downstream
//   out_first/out_last   : sample 0 / sample NPTS-1 markers
//   sat_flag             : this output was clipped (real or imaginary)
//   Optional (SCALE_RESTORE_SAT_CNT_EN): sat_cnt clipped-sample count for
//   the frame, frame_sat sticky any-clip flag.
// Revision    : 1.0 - initial release
// ============================================================================
module scale_restore
    import r4mdc_pkg::*;
#(
    parameter int WL   = WL_DEF,
    parameter int NPTS = NPTS_DEF,
    parameter int SW   = SW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WL-1:0] in_r,
    input  logic [WL-1:0] in_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] shift_amt,
    output logic [WL-1:0] out_r,
    output logic [WL-1:0] out_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          sat_flag
`ifdef SCALE_RESTORE_SAT_CNT_EN
    ,
    output logic [$clog2(NPTS):0] sat_cnt,
    output logic                  frame_sat
`endif
);

    localparam int           CW         = $clog2(NPTS);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(NPTS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [WL-1:0] out_r_q, out_r_d;
    logic [WL-1:0] out_i_q, out_i_d;
    logic          out_valid_q, out_valid_d;
    logic          out_first_q, out_first_d;
    logic          out_last_q, out_last_d;
    logic          sat_flag_q, sat_flag_d;

    logic          w_in_ready;
    logic          w_in_xfer;
    logic [SW-1:0] w_shift_eff;
    logic [WL-1:0] w_res_r, w_res_i;
    logic          w_clip_r, w_clip_i;

    // Sample 0 uses the live shift_amt; later samples the latched copy.
    assign w_shift_eff = (state_q == IDLE) ? shift_amt : shift_q;

    sat_shift_lane #(.WL(WL), .SW(SW)) u_lane_r (
        .i_x    (in_r),
        .i_s    (w_shift_eff),
        .o_y    (w_res_r),
        .o_clip (w_clip_r)
    );

    sat_shift_lane #(.WL(WL), .SW(SW)) u_lane_i (
        .i_x    (in_i),
        .i_s    (w_shift_eff),
        .o_y    (w_res_i),
        .o_clip (w_clip_i)
    );

    // ------------------------------------------------------------------
    // State register (all flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (w_in_xfer) begin
                    shift_d = shift_amt;
                    cnt_d   = CW'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_in_xfer) begin
                    if (cnt_q == C_CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready  = rst_n && (!out_valid_q || out_ready);
        w_in_xfer   = in_valid && w_in_ready;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        sat_flag_d  = sat_flag_q;
        if (w_in_xfer) begin
            out_r_d     = w_res_r;
            out_i_d     = w_res_i;
            out_valid_d = 1'b1;
            out_first_d = (state_q == IDLE);
            out_last_d  = (state_q == RUN) && (cnt_q == C_CNT_LAST);
            sat_flag_d  = w_clip_r | w_clip_i;
        end else if (out_ready) begin
            // Output drained with nothing new behind it; data may hold.
            out_valid_d = 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_flag_q;

`ifdef SCALE_RESTORE_SAT_CNT_EN
    logic [CW:0] sat_cnt_q, sat_cnt_d;
    logic        frame_sat_q, frame_sat_d;
    logic        w_out_xfer;

    assign w_out_xfer = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_q   <= '0;
            frame_sat_q <= 1'b0;
        end else begin
            sat_cnt_q   <= sat_cnt_d;
            frame_sat_q <= frame_sat_d;
        end
    end

    // A transferring first sample restarts the frame tally with its own clip.
    always_comb begin
        sat_cnt_d   = sat_cnt_q;
        frame_sat_d = frame_sat_q;
        if (w_out_xfer) begin
            if (out_first_q) begin
                sat_cnt_d   = (CW + 1)'(sat_flag_q);
                frame_sat_d = sat_flag_q;
            end else begin
                sat_cnt_d   = sat_cnt_q + (CW + 1)'(sat_flag_q);
                frame_sat_d = frame_sat_q | sat_flag_q;
            end
        end
    end

    assign sat_cnt   = sat_cnt_q;
    assign frame_sat = frame_sat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scale_restore.sv
`default_nettype none
// ============================================================================
// Module      : tb_scale_restore
// Description : Self-checking bench for scale_restore (WL=16, NPTS=64, SW=3).
//               Directed vector table plus handshake sequences, checked
//               against a small reference model of frame position and shift.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scale_restore;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_r, in_i;
    logic        in_valid, in_ready;
    logic [2:0]  shift_amt;
    logic [15:0] out_r, out_i;
    logic        out_valid, out_ready, out_first, out_last, sat_flag;
`ifdef SCALE_RESTORE_SAT_CNT_EN
    logic [6:0]  sat_cnt;
    logic        frame_sat;
`endif

    scale_restore #(.WL(16), .NPTS(64), .SW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_amt (shift_amt),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
`ifdef SCALE_RESTORE_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt),
        .frame_sat (frame_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] i;
        logic        first;
        logic        last;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        logic [15:0] er;
        logic [15:0] ei;
        logic        es;
    } vec_t;

    int     n_checks = 0;
    int     n_errors = 0;
    int     n_out    = 0;
    string  phase    = "init";
    exp_t   exp_q[$];
    logic   m_ov     = 1'b0;
    int     m_cnt    = 0;
    logic [2:0] m_shift = 3'd0;
    vec_t   tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL [%s] %s: got %h, expected %h", phase, name, act, req);
        end
    endtask

    // Reference shift-and-saturate, {clip, value}.
    function automatic logic [16:0] mdl(input logic [15:0] x, input logic [2:0] s);
        longint v;
        v = longint'($signed(x)) * (longint'(1) << s);
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    // One clock cycle: drive inputs, check handshake and the pending output,
    // update the model, advance to 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic [15:0] r, input logic [15:0] im,
                        input logic [2:0] sh, input logic ordy, input logic use_tbl,
                        input logic [15:0] er, input logic [15:0] ei, input logic es);
        exp_t        e;
        logic        in_fire, out_fire;
        logic [2:0]  s_eff;
        logic [16:0] mr, mi;
        in_valid  = v;
        in_r      = r;
        in_i      = im;
        shift_amt = sh;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !m_ov || ordy);
        chk("out_valid", out_valid, m_ov);
        if (m_ov && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("out_r", out_r, e.r);
            chk("out_i", out_i, e.i);
            chk("out_first", out_first, e.first);
            chk("out_last", out_last, e.last);
            chk("sat_flag", sat_flag, e.sat);
        end
        in_fire  = v && (!m_ov || ordy);
        out_fire = m_ov && ordy;
        if (out_fire && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_out++;
        end
        if (in_fire) begin
            if (m_cnt == 0) m_shift = sh;
            s_eff   = m_shift;
            e.first = (m_cnt == 0);
            e.last  = (m_cnt == 63);
            if (use_tbl) begin
                e.r   = er;
                e.i   = ei;
                e.sat = es;
            end else begin
                mr    = mdl(r, s_eff);
                mi    = mdl(im, s_eff);
                e.r   = mr[15:0];
                e.i   = mi[15:0];
                e.sat = mr[16] | mi[16];
            end
            exp_q.push_back(e);
            m_cnt = (m_cnt + 1) % 64;
        end
        m_ov = in_fire ? 1'b1 : (ordy ? 1'b0 : m_ov);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 16'h0, 3'd0, ordy, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] kv;
        logic        ordy;
        int          k, cyc;
        logic [3:0]  bp_pat;

        // shift = 2 throughout this table
        tbl[0] = '{16'h1000, 16'hF000, 16'h4000, 16'hC000, 1'b0};
        tbl[1] = '{16'h2001, 16'hF000, 16'h7FFF, 16'hC000, 1'b1};
        tbl[2] = '{16'h1000, 16'hDFFF, 16'h4000, 16'h8000, 1'b1};
        tbl[3] = '{16'h1FFF, 16'hE000, 16'h7FFC, 16'h8000, 1'b0};
        tbl[4] = '{16'hE001, 16'h0001, 16'h8004, 16'h0004, 1'b0};
        tbl[5] = '{16'hFFFF, 16'h0000, 16'hFFFC, 16'h0000, 1'b0};
        tbl[6] = '{16'h2000, 16'hDFFF, 16'h7FFF, 16'h8000, 1'b1};
        tbl[7] = '{16'h0400, 16'hFC00, 16'h1000, 16'hF000, 1'b0};

        // ---------------- reset ----------------
        phase     = "reset";
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_r      = 16'h1234;
        in_i      = 16'h5678;
        shift_amt = 3'd3;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("in_ready", in_ready, 1'b0);
            chk("out_valid", out_valid, 1'b0);
            chk("out_r", out_r, 16'h0);
            chk("out_i", out_i, 16'h0);
            chk("out_first", out_first, 1'b0);
            chk("out_last", out_last, 1'b0);
            chk("sat_flag", sat_flag, 1'b0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("in_ready_release", in_ready, 1'b1);

        // ---------------- pass-through ----------------
        phase = "passthru";
        for (int j = 0; j < 64; j++) begin
            kv = 16'(j);
            step(1'b1, kv, 16'(-j), 3'd0, 1'b1, 1'b1, kv, 16'(-j), 1'b0);
        end
        idle(1'b1);

        // ---------------- table frame, shift 2 ----------------
        phase = "table";
        for (int j = 0; j < 8; j++)
            step(1'b1, tbl[j].r, tbl[j].i, 3'd2, 1'b1, 1'b1, tbl[j].er, tbl[j].ei, tbl[j].es);
        for (int j = 8; j < 64; j++)
            step(1'b1, 16'h0, 16'h0, 3'd2, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0);
        idle(1'b1);
`ifdef SCALE_RESTORE_SAT_CNT_EN
        chk("sat_cnt", sat_cnt, 7'd3);
        chk("frame_sat", frame_sat, 1'b1);
`endif

        // ---------------- shift latching, back-to-back, gaps ----------------
        phase = "latch";
        for (int j = 0; j < 64; j++) begin
            if (j == 5) begin
                idle(1'b1);
                idle(1'b1);
            end
            step(1'b1, 16'h0100 + 16'(j), 16'hFF00 - 16'(j), (j == 0) ? 3'd1 : 3'd5,
                 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        end
        for (int j = 0; j < 64; j++)
            step(1'b1, 16'h0010 + 16'(j), 16'hFFF0 - 16'(j), (j < 2) ? 3'd5 : 3'd0,
                 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(1'b1);

        // ---------------- backpressure ----------------
        phase  = "backpressure";
        n_out  = 0;
        k      = 0;
        cyc    = 0;
        bp_pat = 4'b1001;
        while (k < 64 && cyc < 1000) begin
            ordy = bp_pat[cyc % 4];
            if (!m_ov || ordy) begin
                step(1'b1, 16'h0200 + 16'(k), 16'hFF00 - 16'(k), 3'd3, ordy, 1'b0, 16'h0, 16'h0, 1'b0);
                k++;
            end else begin
                step(1'b1, 16'h0200 + 16'(k), 16'hFF00 - 16'(k), 3'd3, ordy, 1'b0, 16'h0, 16'h0, 1'b0);
            end
            cyc++;
        end
        idle(1'b1);
        idle(1'b1);
        chk("bp_out_count", n_out, 64);
        chk("bp_queue_empty", exp_q.size(), 0);

        // ---------------- mid-frame reset ----------------
        phase = "midreset";
        for (int j = 0; j < 10; j++)
            step(1'b1, 16'(j), 16'(j), 3'd4, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("out_valid_in_reset", out_valid, 1'b0);
        m_ov  = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        rst_n = 1'b1;
        for (int j = 0; j < 64; j++)
            step(1'b1, 16'd100 + 16'(j), 16'd200 - 16'(j), 3'd0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scale_restore.md
Name: scale_restore

Overview:
- Inverse of the per-stage safe downscale in the R4MDC FFT datapath.
- Takes the scaled complex output stream and restores gain by a per-frame left shift, saturating on overflow.
- Sits after the last butterfly/commutator stage, before the output interface.
- Single registered stage with valid/ready backpressure, a frame counter and a per-frame latched shift amount.

Parameters:
- WL, 16: sample word length (two's complement) for each of real and imaginary.
- NPTS, 64: samples per frame; power of two, at least 4.
- SW, 3: width of the shift-amount input; maximum shift is 2^SW-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_r  input  WL  real part of the scaled sample.
- in_i  input  WL  imaginary part of the scaled sample.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- shift_amt  input  SW  left-shift count; sampled only on the first sample of a frame.
- out_r  output  WL  restored real part.
- out_i  output  WL  restored imaginary part.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts the output.
- out_first  output  1  output is sample 0 of a frame.
- out_last  output  1  output is sample NPTS-1 of a frame.
- sat_flag  output  1  this output sample was clipped on real and/or imaginary.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_r=0, out_i=0, out_valid=0, out_first=0, out_last=0, sat_flag=0.
  - Sample counter=0, latched shift=0, FSM enters IDLE.
  - in_ready is combinational and equals 0 while rst_n=0.
- Handshakes:
  - Input transfer occurs when in_valid and in_ready are both 1.
  - Output transfer occurs when out_valid and out_ready are both 1.
  - in_ready = !out_valid || out_ready. This gives full throughput of one sample per cycle with no bubbles.
- Output stability: while out_valid=1 and out_ready=0, all outputs hold.
- Latency: one cycle from input transfer to out_valid=1.
- FSM states:
  - IDLE: waiting for sample 0. On input transfer, latch shift_amt into shift_q, apply shift_amt directly to this sample, set cnt=1, go to RUN.
  - RUN: on input transfer, use shift_q and increment cnt. When the transfer has cnt=NPTS-1, set cnt=0 and go to IDLE.
- Frame control:
  - shift_amt changes during RUN are ignored.
  - out_first is registered with the sample when it entered in IDLE.
  - out_last is registered with the sample when it entered at cnt=NPTS-1.
- Arithmetic, applied per component:
  - Compute the full-precision value x * 2^s, with s from 0 to 2^SW-1.
  - If the result exceeds 2^(WL-1)-1, output 2^(WL-1)-1.
  - If the result is below -2^(WL-1), output -2^(WL-1).
  - Otherwise output the low WL bits.
  - sat_flag = real clipped OR imaginary clipped.
  - s=0 is a pure pass-through.
- Boundary cases:
  - NPTS=4 must cycle IDLE, RUN, RUN, RUN, IDLE.
  - Back-to-back frames have no gap: sample NPTS-1 of one frame and sample 0 of the next may transfer on consecutive cycles. The new shift_amt is latched on the second of these.
  - in_valid deasserted mid-frame: cnt and state hold.
  - Reset mid-frame discards the partial frame. The next accepted sample is treated as sample 0.

Optional Feature:
- Macro SCALE_RESTORE_SAT_CNT_EN.
- When defined:
  - Adds output port sat_cnt, width $clog2(NPTS)+1. It counts clipped samples in the current frame.
  - The count updates on each output transfer. It clears on the transfer of an out_first sample, and that sample's own clip is then counted.
  - Adds output frame_sat, a sticky bit set if any sample of the frame clipped. It is valid alongside out_last and cleared on the next out_first transfer.
  - Both reset to 0.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Package r4mdc_pkg holds:
  - Default WL and NPTS constants.
  - FSM state typedef {IDLE, RUN}.
  - A function sat_shl(x, s), returning the saturated value and a clip bit.
- One sub-module, sat_shift_lane, does the combinational shift-and-saturate for one component. It is instantiated twice, for real and imaginary.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, all outputs 0. First cycle after release, in_ready=1.
- Pass-through: shift_amt=0, stream 64 samples with in_r=k, in_i=-k → out_r=k, out_i=-k one cycle later. out_first on k=0, out_last on k=63, sat_flag=0 throughout.
- Restore by 2: shift_amt=2, in_r=16'h1000, in_i=16'hF000 → out_r=16'h4000, out_i=16'hC000, sat_flag=0. Then in_r=16'h2001 → out_r=16'h7FFF, sat_flag=1. Then in_i=16'hDFFF → out_i=16'h8000, sat_flag=1.
- Shift latching: shift_amt=1 at sample 0, changed to 5 mid-frame → the whole frame uses shift 1. Next frame, sent back-to-back with shift_amt=5, uses 5 from its sample 0.
- Backpressure: out_ready toggles 1,0,0,1 while in_valid=1 → outputs stable while stalled, no sample lost or duplicated, 64 outputs per frame in order.
- Mid-frame reset: apply reset after 10 samples, then send 64 samples → out_first on the first post-reset output, out_last on the 64th. With SCALE_RESTORE_SAT_CNT_EN, a frame with 3 clipped samples shows sat_cnt=3 and frame_sat=1 at out_last.
